// File: rtl/sram_access_controller.sv
// sram_access_controller
// Sequences each 32-bit MEM-stage load/store onto an external 16-bit asynchronous
// SRAM as two half-word phases (low half first), each held for WAIT_CYCLES cycles.
// ready drops while an access is in flight so the pipeline freezes IF..MEM.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   wr_en, rd_en MEM-stage store / load requests (store wins if both are set)
//   address      byte address (ALU result); BASE_ADDR maps to SRAM word 0
//   write_data   store data
//   read_data    registered load result, held until the next load completes
//   ready        1 = pipeline may advance this cycle, 0 = freeze
//   sram_addr    half-word address {word_index, half}
//   sram_dq_out  write data toward the SRAM
//   sram_dq_in   read data from the SRAM
//   sram_dq_oe   1 = controller drives DQ (tristate built at top level)
//   sram_we_n    active-low write strobe
module sram_access_controller #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            op_wr_q;
  logic [16:0]     word_q;
  logic [15:0]     data_hi_q;

  logic            req;
  logic            last;
  logic [31:0]     offset;
  logic [16:0]     word_index;
  logic            unused_offset_bits;

  assign req        = wr_en | rd_en;
  assign last       = (cnt_q == CntLast);
  // Out-of-range addresses simply wrap onto the 2^17-word SRAM.
  assign offset     = address - BASE_ADDR;
  assign word_index = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) state_d = StLow;
      end
      StLow: begin
        if (last) state_d = StHigh;
      end
      StHigh: begin
        if (last) state_d = StDone;
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are loaded on the edge that enters each phase, so they stay
  // stable for the whole phase. Store data low half goes straight from the
  // input; only the high half needs to be kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      data_hi_q   <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            op_wr_q     <= wr_en;
            word_q      <= word_index;
            data_hi_q   <= write_data[31:16];
            cnt_q       <= '0;
            sram_addr   <= {word_index, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        StLow: begin
          if (last) begin
            cnt_q <= '0;
            if (!op_wr_q) read_data[15:0] <= sram_dq_in;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= data_hi_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHigh: begin
          if (last) begin
            cnt_q <= '0;
            if (!op_wr_q) read_data[31:16] <= sram_dq_in;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Self-checking bench for sram_access_controller. Two instances run side by side
// (WAIT_CYCLES = 1 and 3). A simple SRAM array answers the bus; expected results
// come from a word-level store computed from byte addresses.
module tb_sram_access_controller;

  logic        clk;
  logic        rst;
  logic        wr_en       [2];
  logic        rd_en       [2];
  logic [31:0] address     [2];
  logic [31:0] write_data  [2];
  logic [31:0] read_data   [2];
  logic        ready       [2];
  logic [17:0] sram_addr   [2];
  logic [15:0] sram_dq_out [2];
  logic [15:0] sram_dq_in  [2];
  logic        sram_dq_oe  [2];
  logic        sram_we_n   [2];

  logic [15:0] sram0 [262144];
  logic [15:0] sram1 [262144];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  exp_word [int];
  logic [31:0]  last_rd  [2];
  int unsigned  written0 [$];
  int unsigned  written1 [$];

  sram_access_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en[0]),
    .rd_en       (rd_en[0]),
    .address     (address[0]),
    .write_data  (write_data[0]),
    .read_data   (read_data[0]),
    .ready       (ready[0]),
    .sram_addr   (sram_addr[0]),
    .sram_dq_out (sram_dq_out[0]),
    .sram_dq_in  (sram_dq_in[0]),
    .sram_dq_oe  (sram_dq_oe[0]),
    .sram_we_n   (sram_we_n[0])
  );

  sram_access_controller #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en[1]),
    .rd_en       (rd_en[1]),
    .address     (address[1]),
    .write_data  (write_data[1]),
    .read_data   (read_data[1]),
    .ready       (ready[1]),
    .sram_addr   (sram_addr[1]),
    .sram_dq_out (sram_dq_out[1]),
    .sram_dq_in  (sram_dq_in[1]),
    .sram_dq_oe  (sram_dq_oe[1]),
    .sram_we_n   (sram_we_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM stand-in: write while we_n is low, read data follows the address.
  always @(posedge clk) begin
    if (!sram_we_n[0]) sram0[sram_addr[0]] <= sram_dq_out[0];
    if (!sram_we_n[1]) sram1[sram_addr[1]] <= sram_dq_out[1];
  end
  always @(negedge clk) begin
    sram_dq_in[0] <= sram0[sram_addr[0]];
    sram_dq_in[1] <= sram1[sram_addr[1]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] addr);
    logic [31:0] w;
    w = (addr - 32'd1024) / 4;
    return w[16:0];
  endfunction

  // One complete access: checks every cycle's bus/ready values and the final read_data.
  task automatic access(input int k, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit perturb);
    int          wc;
    bit          is_wr;
    logic [16:0] idx;
    int          key;
    wc    = (k == 0) ? 1 : 3;
    is_wr = wr;
    idx   = word_of(addr);
    key   = k * 131072 + int'(idx);
    @(negedge clk);
    wr_en[k] = wr; rd_en[k] = rd; address[k] = addr; write_data[k] = data;
    #1;
    check("req_ready_low", 32'(ready[k]), 32'd0);
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < wc; c++) begin
        @(negedge clk);
        check("busy_ready", 32'(ready[k]), 32'd0);
        check("sram_addr", 32'(sram_addr[k]), 32'({idx, ph[0]}));
        check("we_n", 32'(sram_we_n[k]), 32'(!is_wr));
        check("dq_oe", 32'(sram_dq_oe[k]), 32'(is_wr));
        if (is_wr) check("dq_out", 32'(sram_dq_out[k]), (ph == 0) ? 32'(data[15:0]) : 32'(data[31:16]));
        if (perturb) begin
          address[k] = $urandom; write_data[k] = $urandom;
          wr_en[k] = 1'($urandom); rd_en[k] = 1'($urandom);
        end
      end
    end
    @(negedge clk);
    wr_en[k] = 1'b0; rd_en[k] = 1'b0;
    #1;
    check("done_ready", 32'(ready[k]), 32'd1);
    check("done_we_n", 32'(sram_we_n[k]), 32'd1);
    check("done_oe", 32'(sram_dq_oe[k]), 32'd0);
    if (is_wr) begin
      exp_word[key] = data;
      if (k == 0) written0.push_back(addr); else written1.push_back(addr);
    end else begin
      last_rd[k] = exp_word[key];
    end
    check("read_data", read_data[k], last_rd[k]);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; rd_en[i] = 1'b0; address[i] = '0; write_data[i] = '0; last_rd[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing requested.
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("idle_ready", 32'(ready[i]), 32'd1);
        check("idle_we_n", 32'(sram_we_n[i]), 32'd1);
        check("idle_rdata", read_data[i], 32'd0);
      end
    end

    access(0, 1, 0, 32'd1028, 32'hDEADBEEF, 0);
    access(0, 0, 1, 32'd1028, 32'h0, 0);
    access(1, 1, 0, 32'd1024, 32'hCAFEF00D, 0);
    access(1, 0, 1, 32'd1024, 32'h0, 0);
    // Store wins over load; read_data must not move.
    access(0, 1, 1, 32'd1032, 32'h12345678, 0);
    access(0, 0, 1, 32'd1032, 32'h0, 0);
    // Inputs wiggle mid-access; latched values must stay on the bus.
    access(0, 1, 0, 32'd1037, 32'hA5A55A5A, 1);
    access(0, 0, 1, 32'd1036, 32'h0, 1);
    // Address below BASE_ADDR wraps around the word space.
    access(0, 1, 0, 32'd0, 32'h0BADF00D, 0);
    access(0, 0, 1, 32'd0, 32'h0, 0);

    // Reset during the high phase of a store.
    @(negedge clk);
    wr_en[0] = 1'b1; address[0] = 32'd2000; write_data[0] = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
    wr_en[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_addr_hi", 32'(sram_addr[0]), 32'({word_of(32'd2000), 1'b1}));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_we_n", 32'(sram_we_n[0]), 32'd1);
    check("rst_oe", 32'(sram_dq_oe[0]), 32'd0);
    check("rst_rdata", read_data[0], 32'd0);
    check("rst_addr", 32'(sram_addr[0]), 32'd0);
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    access(0, 0, 1, 32'd1028, 32'h0, 0);
    access(1, 0, 1, 32'd1024, 32'h0, 0);

    // Random mix on both instances.
    for (int n = 0; n < 40; n++) begin
      bit do_wr;
      k = n % 2;
      do_wr = ($urandom_range(0, 1) == 1) || ((k == 0) ? written0.size() == 0 : written1.size() == 0);
      if (do_wr) begin
        a = 32'd1024 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
        access(k, 1, 1'($urandom), a, $urandom, 1'($urandom));
      end else begin
        a = (k == 0) ? written0[$urandom_range(0, written0.size() - 1)]
                     : written1[$urandom_range(0, written1.size() - 1)];
        access(k, 0, 1, a, $urandom, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Sequences every MEM-stage data access onto an external 16-bit asynchronous SRAM, replacing the single-cycle on-chip data memory.
- Each 32-bit word access is split into two 16-bit half-word accesses, each held for a programmable number of wait cycles.
- While an access is in flight, the controller drives ready low so the pipeline hazard/freeze logic stalls IF through MEM.
- Sits between the MEM-stage enables/ALU-result address and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 1, cycles each half-word phase is held on the SRAM bus; legal range is >= 1.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  MEM-stage store request (mem_w_en).
- rd_en  input  1  MEM-stage load request (mem_r_en).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (Rm value).
- read_data  output  32  load result, registered.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_addr  output  18  half-word address {word_index[16:0], half}.
- sram_dq_out  output  16  write data toward the SRAM.
- sram_dq_in  input  16  read data from the SRAM.
- sram_dq_oe  output  1  1 = controller drives DQ (top level builds the tristate).
- sram_we_n  output  1  active-low write strobe.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address map: word_index = (address - BASE_ADDR)[18:2]. address[1:0] is ignored. Out-of-range addresses wrap modulo 2^17 words with no error.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - On a request, latch op, word_index and write_data, clear counter, and go to LOW.
  - wr_en has priority when both enables are high; the access becomes a write.
- LOW:
  - sram_addr = {word_index, 0}.
  - Write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0.
  - Read: sram_dq_oe = 0, sram_we_n = 1.
  - The counter increments each cycle. When counter == WAIT_CYCLES-1: a read captures sram_dq_in into read_data[15:0]; counter clears; go to HIGH.
- HIGH:
  - Same as LOW, but with sram_addr = {word_index, 1} and data[31:16] / read_data[31:16].
  - At the last cycle, go to DONE.
- DONE:
  - ready = 1 for exactly one cycle; bus is idle (we_n = 1, oe = 0); go to IDLE.
  - read_data is fully valid in this cycle and is held until the next read completes. Writes never modify read_data.
- ready is 0 in LOW and HIGH.
- Latency: for a request first seen in IDLE cycle t, ready = 1 in cycle t + 2*WAIT_CYCLES + 1, and the pipeline advances at the end of that cycle.
- Bus outputs (sram_*) are registered. They are set on the edge that enters a phase, so they are stable for the full WAIT_CYCLES of that phase.
- Request inputs are sampled only in IDLE. Changes to inputs during LOW, HIGH or DONE are ignored.
- Back-to-back accesses: a new request present in the IDLE cycle after DONE starts immediately. Minimum spacing between accesses is 2*WAIT_CYCLES + 2 cycles.
- rst asserted mid-access: returns to IDLE at the next edge and applies reset values; a partially written word is left partially written (acceptable).
- sram_we_n and sram_dq_oe are never both inactive/active inconsistently: dq_oe = 1 iff we_n = 0.

Test Plan:
- Idle: rst for 2 cycles, then rd_en = wr_en = 0 -> ready = 1 every cycle, sram_we_n = 1, read_data = 0.
- Write then read, WAIT_CYCLES=1:
  - Store 0xDEADBEEF at 1028 -> sram_addr 2 carries 0xBEEF with we_n = 0 for 1 cycle, then sram_addr 3 carries 0xDEAD.
  - ready = 0, 0, then 1 in the 3rd cycle.
  - Load 1028 -> read_data = 0xDEADBEEF when ready rises.
- Latency, WAIT_CYCLES=3: load at 1024 -> ready low for 6 cycles, high in cycle 7; each half-address is held 3 cycles.
- Both enables high: wr_en = rd_en = 1, data 0x12345678 at 1032 -> write performed (SRAM words 4, 5 = 0x5678, 0x1234); read_data unchanged.
- Reset mid-op: assert rst during HIGH of a write -> next cycle state IDLE, ready = 1 with no request, we_n = 1, read_data = 0; a subsequent load still completes in 3 cycles.
- Input change mid-op: change address/write_data during LOW -> the originally latched values appear on the bus for both halves.
